// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of an asynchronous slow
// signal in system-clock cycles, and flags when it stops toggling.
module clk_period_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  typedef enum logic {ACQUIRE, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;
  logic                   s, rise, fall;
  logic [CNT_W-1:0]       pcnt, hcnt, h_lat;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      p      <= s;
    end
  end

  // Rise-to-rise and high-time counters; both restart at 1 on the rise so a
  // counter value equals the number of cycles since (and including) the rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= '0;
      hcnt  <= '0;
      h_lat <= '0;
    end else begin
      if (rise)                 pcnt <= ONE;
      else if (pcnt != CNT_MAX) pcnt <= pcnt + ONE;

      if (rise)                      hcnt <= ONE;
      else if (s && hcnt != CNT_MAX) hcnt <= hcnt + ONE;

      if (fall) h_lat <= hcnt;
    end
  end

  // Acquire/measure FSM with registered results; a rise beats a coincident timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQUIRE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ACQUIRE: begin
          if (rise) begin
            state  <= MEASURE;
            locked <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period     <= pcnt;
            high_time  <= h_lat;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            locked     <= 1'b1;
          end else if (pcnt >= TO_CNT) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            state   <= ACQUIRE;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: stimulus pushes the expected
// (period, high_time, spacing) of each completed sig_in period into a
// scoreboard; a monitor pops and compares on every meas_valid.
module tb_clk_period_meter;

  localparam int CNT_W = 32;
  localparam int SYNC  = 2;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, timeout, locked;

  typedef struct {
    int p;
    int h;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_vcyc = 0;

  // stimulus model state
  bit armed = 0;
  bit last_pushed = 0;
  int prev_p = 0;
  int prev_h = 0;

  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .timeout(timeout), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a rising sig_in; the period that just completed becomes an expectation
  task automatic drive_rise(input int p, input int h);
    sig_in = 1'b1;
    if (armed) begin
      sb.push_back('{p: prev_p, h: prev_h, gap: (last_pushed ? prev_p : 0)});
      last_pushed = 1;
    end else begin
      last_pushed = 0;
    end
    armed  = 1;
    prev_p = p;
    prev_h = h;
  endtask

  task automatic period_cycle(input int p, input int h);
    drive_rise(p, h);
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      chk("sb_has_entry", longint'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("period", period, e.p);
        chk("high_time", high_time, e.h);
        chk("locked_at_valid", locked, 1);
        chk("timeout_at_valid", timeout, 0);
        if (e.gap != 0) chk("valid_gap", cyc - last_vcyc, e.gap);
      end
      last_vcyc = cyc;
    end
  end

  initial begin
    // Reset held with sig_in toggling: no output activity
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
      chk("rst_meas_valid", meas_valid, 0);
    end
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_locked", locked, 0);
    @(negedge clk);
    sig_in = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Divide-by-16, 50% duty: first rise only acquires
    period_cycle(16, 8);
    chk("acq_locked", locked, 0);
    chk("acq_period", period, 0);
    repeat (4) period_cycle(16, 8);

    // 25% duty at period 40, then switch to period 20
    repeat (3) period_cycle(40, 10);
    repeat (3) period_cycle(20, 5);

    // Last rise, then stuck low: timeout exactly TO clks after the rise is seen
    drive_rise(20, 5);
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (SYNC + TO - 5) @(negedge clk);
    chk("pre_timeout", timeout, 0);
    chk("pre_timeout_locked", locked, 1);
    @(negedge clk);
    chk("timeout_set", timeout, 1);
    chk("timeout_locked", locked, 0);
    chk("timeout_keep_period", period, 20);
    chk("timeout_keep_high", high_time, 5);
    armed = 0;
    repeat (20) @(negedge clk);
    chk("timeout_sticky", timeout, 1);

    // Recovery: first rise re-acquires, timeout clears on the second
    period_cycle(16, 8);
    chk("reacq_timeout", timeout, 1);
    chk("reacq_locked", locked, 0);
    repeat (2) period_cycle(16, 8);

    // Async reset mid-period, off the clock edge
    drive_rise(16, 8);
    repeat (5) @(negedge clk);
    chk("sb_drained_pre_rst", sb.size(), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_high_time", high_time, 0);
    chk("arst_valid", meas_valid, 0);
    chk("arst_locked", locked, 0);
    chk("arst_timeout", timeout, 0);
    armed = 0;
    last_pushed = 0;
    @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    period_cycle(16, 8);
    chk("post_rst_locked", locked, 0);
    chk("post_rst_period", period, 0);

    // Minimum period: toggle every clk
    repeat (10) period_cycle(2, 1);
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_drained_end", sb.size(), 0);
    chk("end_period", period, 2);
    chk("end_high_time", high_time, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
